// File: rtl/zx_kbd_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// zx_kbd_pkg
// Shared constants and types for the keyboard/joystick SPI link receiver.
// A frame carries the 8x5 ZX matrix (active-low, row0 first, column 4 first)
// followed by the Kempston joystick byte (active-high, bit 7 first).
// -----------------------------------------------------------------------------
package zx_kbd_pkg;

    localparam int FRAME_BITS  = 48;
    localparam int MATRIX_BITS = 40;
    localparam int ROWS        = 8;
    localparam int COLS        = 5;
    localparam int JOY_BITS    = FRAME_BITS - MATRIX_BITS;
    localparam int CNT_W       = 6;

    localparam logic [COLS-1:0]     ROW_IDLE = 5'b11111;
    localparam logic [JOY_BITS-1:0] JOY_IDLE = 8'h00;

    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Committed frame image; the layout matches the shift register so a
    // commit is a single whole-vector copy.
    typedef struct packed {
        logic [MATRIX_BITS-1:0] rows;
        logic [JOY_BITS-1:0]    joy;
    } shadow_t;

    localparam shadow_t SHADOW_IDLE = '{rows: {ROWS{ROW_IDLE}}, joy: JOY_IDLE};

    // Row 0 arrives first, so it ends up in the most significant slice.
    function automatic int row_lsb(input int row);
        return (ROWS - 1 - row) * COLS;
    endfunction

endpackage

// File: rtl/zx_sync_edge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// zx_sync_edge
// Multi-flop synchronizer for one asynchronous input plus one history flop
// for rise/fall detection.
//   clk    in   system clock
//   rst_n  in   async active-low reset (already release-synchronized)
//   d      in   asynchronous input pin
//   q      out  synchronized level
//   rise   out  q went 0->1 this cycle (combinational from flops)
//   fall   out  q went 1->0 this cycle (combinational from flops)
// -----------------------------------------------------------------------------
module zx_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // NOTE: flops use non-blocking assignments so every stage samples the
    // value its predecessor held before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise =  q & ~prev_q;
    assign fall = ~q &  prev_q;

endmodule

// File: rtl/zx_kbd_spi_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// zx_kbd_spi_rx
// SPI mode-0 slave that receives 48-bit keyboard/joystick frames and holds the
// last good frame in shadow registers for the CPU read mux.
//   CLK_14MHZ  in   system clock
//   CPU_RESET  in   async active-low reset (release synchronized internally)
//   KBD_CLK    in   SPI clock, asynchronous
//   KBD_CS     in   frame select, active-low
//   KBD_DI     in   serial data, MSB first
//   A_HI[7:0]  in   CPU A[15:8]; a 0 bit selects that half-row
//   KD[4:0]    out  port #FE key columns, active-low, combinational from A_HI
//   JOY[7:0]   out  port #1F Kempston byte
//   FRAME_OK   out  one-cycle pulse on commit
//   FRAME_ERR  out  one-cycle pulse on discarded frame
// -----------------------------------------------------------------------------
module zx_kbd_spi_rx
    import zx_kbd_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK_14MHZ,
    input  logic                CPU_RESET,
    input  logic                KBD_CLK,
    input  logic                KBD_CS,
    input  logic                KBD_DI,
    input  logic [ROWS-1:0]     A_HI,
    output logic [COLS-1:0]     KD,
    output logic [JOY_BITS-1:0] JOY,
    output logic                FRAME_OK,
    output logic                FRAME_ERR
);

    // ------------------------------------------------------------------
    // Reset release synchronizer: assert asynchronously, release on CLK.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
        if (!CPU_RESET) rst_sync_q <= '0;
        else            rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Pin synchronizers. CS resets to 0 so that a CS already high at reset
    // release shows up as a rise while still unarmed, and is ignored.
    // ------------------------------------------------------------------
    logic clk_sync_unused, clk_rise, clk_fall_unused;
    logic cs_sync, cs_rise, cs_fall;
    logic di_sync, di_rise_unused, di_fall_unused;

    zx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
        .clk (CLK_14MHZ), .rst_n (rst_n), .d (KBD_CLK),
        .q   (clk_sync_unused), .rise (clk_rise), .fall (clk_fall_unused)
    );

    zx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk (CLK_14MHZ), .rst_n (rst_n), .d (KBD_CS),
        .q   (cs_sync), .rise (cs_rise), .fall (cs_fall)
    );

    zx_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_di (
        .clk (CLK_14MHZ), .rst_n (rst_n), .d (KBD_DI),
        .q   (di_sync), .rise (di_rise_unused), .fall (di_fall_unused)
    );

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    logic                  armed_q, armed_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    shadow_t               shadow_q, shadow_d;
    logic                  frame_ok_q, frame_ok_d;
    logic                  frame_err_q, frame_err_d;

    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        armed_d     = armed_q | cs_sync;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        shift_d     = shift_q;
        shadow_d    = shadow_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;

        if (armed_q) begin
            // Ordering within the cycle: clear on CS fall, then take the bit,
            // then judge the count on CS rise (so a coincident bit counts).
            if (cs_fall) begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end

            if (clk_rise && (!cs_sync || cs_rise)) begin
                if (cnt_d >= CNT_FRAME) ovf_d   = 1'b1;
                else                    shift_d = {shift_q[FRAME_BITS-2:0], di_sync};
                if (cnt_d != CNT_MAX)   cnt_d   = cnt_d + 1'b1;
            end

            if (cs_rise) begin
                if (cnt_d == CNT_FRAME && !ovf_d) begin
                    shadow_d   = shadow_t'(shift_d);
                    frame_ok_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK_14MHZ or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            shadow_q    <= SHADOW_IDLE;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            shadow_q    <= shadow_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

    // NOTE: the shift register carries no reset; it can only be committed
    // after 48 fresh bits following a counter clear, so stale contents are
    // never visible.
    always_ff @(posedge CLK_14MHZ) begin
        shift_q <= shift_d;
    end

    // ------------------------------------------------------------------
    // Half-row select: AND together every row whose address bit is low.
    // ------------------------------------------------------------------
    logic [ROWS:0][COLS-1:0] kd_chain;

    assign kd_chain[0] = ROW_IDLE;

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        assign kd_chain[i+1] = kd_chain[i] &
                               (A_HI[i] ? ROW_IDLE : shadow_q.rows[row_lsb(i) +: COLS]);
    end

    assign KD        = kd_chain[ROWS];
    assign JOY       = shadow_q.joy;
    assign FRAME_OK  = frame_ok_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_zx_kbd_spi_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_zx_kbd_spi_rx
// Drives randomized keyboard frames over the SPI pins and compares KD/JOY and
// the frame pulses against a simple model holding the last good frame.
// -----------------------------------------------------------------------------
module tb_zx_kbd_spi_rx;

    logic       CLK_14MHZ = 1'b0;
    logic       CPU_RESET = 1'b0;
    logic       KBD_CLK   = 1'b0;
    logic       KBD_CS    = 1'b1;
    logic       KBD_DI    = 1'b0;
    logic [7:0] A_HI      = 8'hFE;
    logic [4:0] KD;
    logic [7:0] JOY;
    logic       FRAME_OK;
    logic       FRAME_ERR;

    int n_checks = 0;
    int n_fail   = 0;
    int ok_cnt   = 0;
    int err_cnt  = 0;

    // Model: last committed frame, and the frame about to be sent.
    logic [4:0] exp_row [8];
    logic [7:0] exp_joy;
    logic [4:0] new_row [8];
    logic [7:0] new_joy;
    bit         tx_bits [$];

    always #35 CLK_14MHZ = ~CLK_14MHZ;

    zx_kbd_spi_rx #(.SYNC_STAGES(2)) dut (
        .CLK_14MHZ (CLK_14MHZ),
        .CPU_RESET (CPU_RESET),
        .KBD_CLK   (KBD_CLK),
        .KBD_CS    (KBD_CS),
        .KBD_DI    (KBD_DI),
        .A_HI      (A_HI),
        .KD        (KD),
        .JOY       (JOY),
        .FRAME_OK  (FRAME_OK),
        .FRAME_ERR (FRAME_ERR)
    );

    always @(negedge CLK_14MHZ) begin
        if (FRAME_OK)  ok_cnt++;
        if (FRAME_ERR) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_kd(input logic [7:0] a);
        logic [4:0] kd = 5'b11111;
        for (int i = 0; i < 8; i++)
            if (!a[i]) kd &= exp_row[i];
        return kd;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) exp_row[i] = 5'b11111;
        exp_joy = 8'h00;
    endtask

    task automatic model_commit();
        for (int i = 0; i < 8; i++) exp_row[i] = new_row[i];
        exp_joy = new_joy;
    endtask

    task automatic random_frame();
        for (int i = 0; i < 8; i++) new_row[i] = 5'($urandom);
        new_joy = 8'($urandom);
    endtask

    task automatic idle_frame();
        for (int i = 0; i < 8; i++) new_row[i] = 5'b11111;
        new_joy = 8'h00;
    endtask

    // Serialize: row0 col4 first ... row7 col0, then joystick bit 7 .. bit 0.
    task automatic build_bits();
        tx_bits.delete();
        for (int r = 0; r < 8; r++)
            for (int c = 4; c >= 0; c--) tx_bits.push_back(new_row[r][c]);
        for (int j = 7; j >= 0; j--) tx_bits.push_back(new_joy[j]);
    endtask

    // One SPI bit at 3.5 MHz: 140 ns low with data set, 140 ns high.
    task automatic clock_bit(input bit b);
        KBD_DI = b;
        #140 KBD_CLK = 1'b1;
        #140 KBD_CLK = 1'b0;
    endtask

    task automatic send_frame(input string tag, input int n, input bit coincident);
        int ok0  = ok_cnt;
        int err0 = err_cnt;
        bit b;
        bit good = (n == 48);
        KBD_CS = 1'b0;
        #315;
        for (int i = 0; i < n; i++) begin
            b = (i < tx_bits.size()) ? tx_bits[i] : 1'($urandom);
            if (coincident && i == n - 1) begin
                KBD_DI = b;
                #140;
                KBD_CLK = 1'b1;
                KBD_CS  = 1'b1;
                #140 KBD_CLK = 1'b0;
            end else begin
                clock_bit(b);
            end
        end
        if (!coincident) #140 KBD_CS = 1'b1;
        #1050;
        if (good) model_commit();
        check({tag, " frame_ok count"},  32'(ok_cnt - ok0),   32'(good));
        check({tag, " frame_err count"}, 32'(err_cnt - err0), 32'(!good));
    endtask

    task automatic probe(input string tag, input logic [7:0] a, input logic [4:0] exp);
        @(negedge CLK_14MHZ);
        A_HI = a;
        #5 check($sformatf("%s kd a_hi=%h", tag, a), 32'(KD), 32'(exp));
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] a;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0:       a = 8'hFF;
                1:       a = 8'h00;
                2:       a = ~(8'h01 << $urandom_range(0, 7));
                default: a = 8'($urandom);
            endcase
            probe(tag, a, model_kd(a));
        end
        check({tag, " joy"}, 32'(JOY), 32'(exp_joy));
    endtask

    initial begin
        int ok0, err0;
        model_reset();

        // Reset held with CS high.
        #12;
        #350;
        check("reset kd",        32'(KD),        32'h1F);
        check("reset joy",       32'(JOY),       32'h00);
        check("reset frame_ok",  32'(FRAME_OK),  32'h0);
        check("reset frame_err", 32'(FRAME_ERR), 32'h0);
        CPU_RESET = 1'b1;
        #1400;
        check("post-reset ok pulses",  32'(ok_cnt),  32'h0);
        check("post-reset err pulses", 32'(err_cnt), 32'h0);
        check_outputs("idle");

        // CAPS pressed, fire on joystick.
        idle_frame();
        new_row[0] = 5'b11110;
        new_joy    = 8'h10;
        build_bits();
        send_frame("caps", 48, 1'b0);
        probe("caps", 8'hFE, 5'b11110);
        probe("caps", 8'h7F, 5'b11111);
        check("caps joy", 32'(JOY), 32'h10);

        // Two rows combine under a multi-row select.
        idle_frame();
        new_row[3] = 5'b01111;
        new_row[4] = 5'b11101;
        new_joy    = 8'h05;
        build_bits();
        send_frame("rows34", 48, 1'b0);
        probe("rows34", 8'h00, 5'b01101);
        probe("rows34", 8'hEF, 5'b11101);
        check_outputs("rows34");

        // Short, long and empty frames are discarded.
        random_frame();
        build_bits();
        send_frame("short47", 47, 1'b0);
        check_outputs("short47");
        send_frame("long49", 49, 1'b0);
        check_outputs("long49");
        send_frame("empty", 0, 1'b0);
        check_outputs("empty");
        send_frame("after_err", 48, 1'b0);
        check_outputs("after_err");

        // Reset mid-frame; the remainder of that frame must be ignored.
        ok0  = ok_cnt;
        err0 = err_cnt;
        random_frame();
        build_bits();
        KBD_CS = 1'b0;
        #315;
        for (int i = 0; i < 20; i++) clock_bit(tx_bits[i]);
        #105 CPU_RESET = 1'b0;
        #210 CPU_RESET = 1'b1;
        for (int i = 20; i < 48; i++) clock_bit(tx_bits[i]);
        #140 KBD_CS = 1'b1;
        #1050;
        model_reset();
        check("midreset ok pulses",  32'(ok_cnt - ok0),   32'h0);
        check("midreset err pulses", 32'(err_cnt - err0), 32'h0);
        check_outputs("midreset");
        random_frame();
        build_bits();
        send_frame("post_midreset", 48, 1'b0);
        check_outputs("post_midreset");

        // CS rise on the same system cycle as the last clock rise.
        random_frame();
        new_joy[0] = 1'b1;
        build_bits();
        send_frame("coincident", 48, 1'b1);
        check("coincident joy0", 32'(JOY[0]), 32'h1);
        check_outputs("coincident");

        // Randomized frames with occasional bad lengths and coincident ends.
        for (int f = 0; f < 20; f++) begin
            int r = $urandom_range(0, 9);
            int n = (r == 0) ? 47 : (r == 1) ? 49 : 48;
            random_frame();
            build_bits();
            send_frame($sformatf("rnd%0d", f), n, r == 2);
            check_outputs($sformatf("rnd%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
